// File: rtl/hold_window_monitor.sv
// hold_window_monitor
//   Watches a level "window" signal and a toggle signal coming from a
//   hold-style FSM. It measures how many clk cycles each window is high,
//   counts toggle events inside the window, and queues one record per window
//   in a small FIFO. Records are drained through a valid/ready port.
//
// Parameters
//   CNT_W  width of the window-length counter (saturates at all-ones)
//   TGL_W  width of the toggle-event counter (saturates at all-ones)
//   DEPTH  record FIFO entries, power of two, >= 2
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   win_in     window level, synchronous to clk
//   tgl_in     toggle signal; every level change is one event
//   clr        synchronous flush of FIFO, ovf and measurement
//   rec_valid  FIFO head record available
//   rec_ready  consumer accepts head when rec_valid & rec_ready
//   rec_width  head record: cycles win_in was sampled high
//   rec_tgl    head record: toggle events during the window
//   ovf        sticky flag: a record was dropped because the FIFO was full
//   busy       measurement FSM is not idle

module hold_window_monitor #(
    parameter int CNT_W = 8,
    parameter int TGL_W = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             win_in,
    input  logic             tgl_in,
    input  logic             clr,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [CNT_W-1:0] rec_width,
    output logic [TGL_W-1:0] rec_tgl,
    output logic             ovf,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        MEAS,
        PUSH
    } state_t;

    state_t state, state_nxt;

    logic win_q, tgl_q;
    logic rise, tev;

    logic [CNT_W-1:0] width, width_nxt;
    logic [TGL_W-1:0] tcnt, tcnt_nxt;

    logic             wr_en_q;
    logic [CNT_W-1:0] wr_width_q;
    logic [TGL_W-1:0] wr_tgl_q;

    logic [CNT_W-1:0] mem_width [DEPTH];
    logic [TGL_W-1:0] mem_tgl   [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr, rd_ptr_inc;
    logic [AW:0]      count;

    logic             pop, push, drop, full;
    logic [CNT_W-1:0] head_width_nxt;
    logic [TGL_W-1:0] head_tgl_nxt;

    function automatic logic [CNT_W-1:0] sat_w(input logic [CNT_W-1:0] a,
                                               input logic inc);
        return (inc && (a != '1)) ? a + CNT_W'(1) : a;
    endfunction

    function automatic logic [TGL_W-1:0] sat_t(input logic [TGL_W-1:0] a,
                                               input logic inc);
        return (inc && (a != '1)) ? a + TGL_W'(1) : a;
    endfunction

    // Input history keeps sampling through clr so that a window already open
    // when clr releases does not look like a fresh rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q <= 1'b0;
            tgl_q <= 1'b0;
        end else begin
            win_q <= win_in;
            tgl_q <= tgl_in;
        end
    end

    assign rise = win_in & ~win_q;
    assign tev  = tgl_in ^ tgl_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            width <= '0;
            tcnt  <= '0;
        end else begin
            state <= state_nxt;
            width <= width_nxt;
            tcnt  <= tcnt_nxt;
        end
    end

    // PUSH samples win_in directly: a high level there always follows the
    // low fall sample, so it starts a back-to-back window.
    always_comb begin
        state_nxt = state;
        width_nxt = width;
        tcnt_nxt  = tcnt;
        if (clr) begin
            state_nxt = IDLE;
            width_nxt = '0;
            tcnt_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        state_nxt = MEAS;
                        width_nxt = CNT_W'(1);
                        tcnt_nxt  = TGL_W'(tev);
                    end
                end
                MEAS: begin
                    tcnt_nxt = sat_t(tcnt, tev);
                    if (win_in) begin
                        width_nxt = sat_w(width, 1'b1);
                    end else begin
                        state_nxt = PUSH;
                    end
                end
                PUSH: begin
                    if (win_in) begin
                        state_nxt = MEAS;
                        width_nxt = CNT_W'(1);
                        tcnt_nxt  = TGL_W'(tev);
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // The finished record is staged for one cycle before it enters the FIFO,
    // so the head becomes visible two cycles after the first low sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q    <= 1'b0;
            wr_width_q <= '0;
            wr_tgl_q   <= '0;
        end else begin
            wr_en_q    <= (state == PUSH) && !clr;
            wr_width_q <= width;
            wr_tgl_q   <= tcnt;
        end
    end

    assign rec_valid  = (count != '0);
    assign full       = (count == FULL_CNT);
    assign pop        = rec_valid & rec_ready;
    assign push       = wr_en_q & (~full | pop);
    assign drop       = wr_en_q & full & ~pop;
    assign rd_ptr_inc = rd_ptr + AW'(1);

    // The head is held in output registers so rec_* stay stable while the
    // FIFO is empty, instead of exposing whatever stale slot rd_ptr points at.
    always_comb begin
        head_width_nxt = rec_width;
        head_tgl_nxt   = rec_tgl;
        if (pop) begin
            if (count > (AW+1)'(1)) begin
                head_width_nxt = mem_width[rd_ptr_inc];
                head_tgl_nxt   = mem_tgl[rd_ptr_inc];
            end else if (push) begin
                head_width_nxt = wr_width_q;
                head_tgl_nxt   = wr_tgl_q;
            end
        end else if (!rec_valid && push) begin
            head_width_nxt = wr_width_q;
            head_tgl_nxt   = wr_tgl_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem_width[wr_ptr] <= wr_width_q;
            mem_tgl[wr_ptr]   <= wr_tgl_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            rec_width <= '0;
            rec_tgl   <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (drop) begin
                ovf <= 1'b1;
            end
            rec_width <= head_width_nxt;
            rec_tgl   <= head_tgl_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule
